// File: rtl/alu_flag_wb.sv
// ============================================================================
// Module   : alu_flag_wb
// Brief    : Condition-gated ALU writeback stage with status flags and 2-deep FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_wb #(
    parameter int B_W  = 4,
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            InValid,
    output logic            InReady,
    input  logic [B_W-1:0]  InResult,
    input  logic            InFlagN,
    input  logic            InFlagZ,
    input  logic            InFlagC,
    input  logic            InFlagV,
    input  logic [3:0]      InCond,
    input  logic            InSetFlags,
    input  logic [RD_W-1:0] InRd,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [B_W-1:0]  OutResult,
    output logic [RD_W-1:0] OutRd,
    output logic            OutWrite,
    output logic [3:0]      FlagsOut,
    output logic            ALUFlagIn,
    output logic [7:0]      CondFailCount
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [7:0] c_FAIL_MAX = 8'hFF;

    state_t          r_state;
    state_t          w_state_nxt;

    // Flags are kept as {N,Z,C,V}
    logic [3:0]      r_flags;
    logic            w_n, w_z, w_c, w_v;
    logic            w_cond_pass;
    logic            w_push;
    logic            w_pop;

    // Head entry drives the outputs directly; tail is the second slot
    logic [B_W-1:0]  r_head_result;
    logic [RD_W-1:0] r_head_rd;
    logic            r_head_write;
    logic [B_W-1:0]  r_tail_result;
    logic [RD_W-1:0] r_tail_rd;
    logic            r_tail_write;
    logic [7:0]      r_fail_cnt;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_cond_pass = 1'b0;
        case (InCond)
            4'h0: w_cond_pass = w_z;
            4'h1: w_cond_pass = ~w_z;
            4'h2: w_cond_pass = w_c;
            4'h3: w_cond_pass = ~w_c;
            4'h4: w_cond_pass = w_n;
            4'h5: w_cond_pass = ~w_n;
            4'h6: w_cond_pass = w_v;
            4'h7: w_cond_pass = ~w_v;
            4'h8: w_cond_pass = w_c & ~w_z;
            4'h9: w_cond_pass = ~w_c | w_z;
            4'hA: w_cond_pass = (w_n == w_v);
            4'hB: w_cond_pass = (w_n != w_v);
            4'hC: w_cond_pass = ~w_z & (w_n == w_v);
            4'hD: w_cond_pass = w_z | (w_n != w_v);
            4'hE: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign InReady  = (r_state != ST_FULL);
    assign OutValid = (r_state != ST_EMPTY);
    assign w_push   = InValid & InReady;
    assign w_pop    = OutValid & OutReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_result <= '0;
            r_head_rd     <= '0;
            r_head_write  <= 1'b0;
            r_tail_result <= '0;
            r_tail_rd     <= '0;
            r_tail_write  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_result <= InResult;
                        r_head_rd     <= InRd;
                        r_head_write  <= w_cond_pass;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_result <= InResult;
                        r_head_rd     <= InRd;
                        r_head_write  <= w_cond_pass;
                    end else if (w_push) begin
                        r_tail_result <= InResult;
                        r_tail_rd     <= InRd;
                        r_tail_write  <= w_cond_pass;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head_result <= r_tail_result;
                        r_head_rd     <= r_tail_rd;
                        r_head_write  <= r_tail_write;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flag update and fail counting happen at push, so a following push sees the new flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags    <= 4'b0000;
            r_fail_cnt <= 8'd0;
        end else if (w_push) begin
            if (w_cond_pass && InSetFlags) begin
                r_flags <= {InFlagN, InFlagZ, InFlagC, InFlagV};
            end
            if (!w_cond_pass && (r_fail_cnt != c_FAIL_MAX)) begin
                r_fail_cnt <= r_fail_cnt + 8'd1;
            end
        end
    end

    assign OutResult     = r_head_result;
    assign OutRd         = r_head_rd;
    assign OutWrite      = r_head_write;
    assign FlagsOut      = r_flags;
    assign ALUFlagIn     = r_flags[1];
    assign CondFailCount = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_flag_wb.sv
// ============================================================================
// Module   : tb_alu_flag_wb
// Brief    : Directed self-checking bench for alu_flag_wb
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_flag_wb;

    logic       clk;
    logic       rst;
    logic       InValid;
    logic       InReady;
    logic [3:0] InResult;
    logic       InFlagN, InFlagZ, InFlagC, InFlagV;
    logic [3:0] InCond;
    logic       InSetFlags;
    logic [3:0] InRd;
    logic       OutValid;
    logic       OutReady;
    logic [3:0] OutResult;
    logic [3:0] OutRd;
    logic       OutWrite;
    logic [3:0] FlagsOut;
    logic       ALUFlagIn;
    logic [7:0] CondFailCount;

    int total = 0;
    int bad   = 0;

    alu_flag_wb #(.B_W(4), .RD_W(4)) dut (
        .clk(clk), .rst(rst),
        .InValid(InValid), .InReady(InReady), .InResult(InResult),
        .InFlagN(InFlagN), .InFlagZ(InFlagZ), .InFlagC(InFlagC), .InFlagV(InFlagV),
        .InCond(InCond), .InSetFlags(InSetFlags), .InRd(InRd),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
        .OutRd(OutRd), .OutWrite(OutWrite), .FlagsOut(FlagsOut),
        .ALUFlagIn(ALUFlagIn), .CondFailCount(CondFailCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // flags given as {N,Z,C,V}
    task automatic push(input logic [3:0] res, input logic [3:0] rd, input logic [3:0] fl,
                        input logic [3:0] cond, input logic setf);
        InValid    = 1'b1;
        InResult   = res;
        InRd       = rd;
        {InFlagN, InFlagZ, InFlagC, InFlagV} = fl;
        InCond     = cond;
        InSetFlags = setf;
        cycle();
    endtask

    typedef struct {
        logic [3:0] fl;
        logic [3:0] cond;
        logic       pass;
    } cvec_t;

    cvec_t cvec[10] = '{
        '{4'b0100, 4'h0, 1'b1},
        '{4'b0100, 4'h8, 1'b0},
        '{4'b0010, 4'h8, 1'b1},
        '{4'b1000, 4'hA, 1'b0},
        '{4'b1001, 4'hA, 1'b1},
        '{4'b1000, 4'hB, 1'b1},
        '{4'b0000, 4'hC, 1'b1},
        '{4'b0100, 4'hD, 1'b1},
        '{4'b0001, 4'h6, 1'b1},
        '{4'b0000, 4'hF, 1'b0}
    };

    logic any_write;

    initial begin
        rst = 1'b1;
        InValid = 1'b0; InResult = '0; InRd = '0;
        {InFlagN, InFlagZ, InFlagC, InFlagV} = 4'b0000;
        InCond = 4'hE; InSetFlags = 1'b0; OutReady = 1'b0;

        #2;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_inready", InReady, 1);
        chk("rst_flags", FlagsOut, 0);
        chk("rst_aluflag", ALUFlagIn, 0);
        chk("rst_result", OutResult, 0);
        chk("rst_rd", OutRd, 0);
        chk("rst_write", OutWrite, 0);
        chk("rst_failcnt", CondFailCount, 0);
        #10 rst = 1'b0;

        // first push sets C
        OutReady = 1'b1;
        push(4'b0110, 4'd3, 4'b0010, 4'hE, 1'b1);
        chk("p1_valid", OutValid, 1);
        chk("p1_result", OutResult, 4'b0110);
        chk("p1_rd", OutRd, 3);
        chk("p1_write", OutWrite, 1);
        chk("p1_flags", FlagsOut, 4'b0010);
        chk("p1_aluflag", ALUFlagIn, 1);

        push(4'd7, 4'd4, 4'b0000, 4'h2, 1'b0);
        chk("cs_result", OutResult, 7);
        chk("cs_write", OutWrite, 1);
        push(4'd8, 4'd5, 4'b0100, 4'h3, 1'b1);
        chk("cc_result", OutResult, 8);
        chk("cc_write", OutWrite, 0);
        chk("cc_failcnt", CondFailCount, 1);
        chk("cc_flags", FlagsOut, 4'b0010);
        InValid = 1'b0;
        cycle();
        chk("drain_valid", OutValid, 0);
        chk("hold_result", OutResult, 8);
        chk("hold_rd", OutRd, 5);

        // condition table: set flags with AL, then test the code
        foreach (cvec[i]) begin
            push(4'd1, 4'd0, cvec[i].fl, 4'hE, 1'b1);
            push(4'd2, 4'd0, 4'b1111, cvec[i].cond, 1'b0);
            chk($sformatf("cond%0h_%0d", cvec[i].cond, i), OutWrite, cvec[i].pass);
        end
        InValid = 1'b0;
        cycle();

        // backpressure ordering
        OutReady = 1'b0;
        push(4'd1, 4'd1, 4'b0000, 4'hE, 1'b0);
        chk("bp_ready1", InReady, 1);
        push(4'd2, 4'd2, 4'b0000, 4'hE, 1'b0);
        chk("bp_ready2", InReady, 0);
        push(4'd3, 4'd3, 4'b0000, 4'hE, 1'b0);
        chk("bp_full_hold", OutResult, 1);
        chk("bp_full_ready", InReady, 0);
        OutReady = 1'b1;
        cycle();
        chk("bp_out2", OutResult, 2);
        chk("bp_ready_after_pop", InReady, 1);
        cycle();
        chk("bp_out3", OutResult, 3);
        chk("bp_out3_valid", OutValid, 1);
        InValid = 1'b0;
        cycle();
        chk("bp_empty", OutValid, 0);

        // simultaneous push/pop in ONE
        OutReady = 1'b0;
        push(4'h5, 4'd0, 4'b0000, 4'hE, 1'b0);
        OutReady = 1'b1;
        push(4'h9, 4'd0, 4'b0000, 4'hE, 1'b0);
        chk("pp_result", OutResult, 4'h9);
        chk("pp_one_ready", InReady, 1);
        InValid = 1'b0;
        cycle();
        chk("pp_empty", OutValid, 0);

        // asynchronous reset while FULL
        OutReady = 1'b0;
        push(4'hC, 4'd1, 4'b1001, 4'hE, 1'b1);
        push(4'hD, 4'd2, 4'b0000, 4'hE, 1'b0);
        InValid = 1'b0;
        chk("full_flags", FlagsOut, 4'b1001);
        chk("full_ready", InReady, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_outvalid", OutValid, 0);
        chk("ar_inready", InReady, 1);
        chk("ar_flags", FlagsOut, 0);
        chk("ar_aluflag", ALUFlagIn, 0);
        chk("ar_failcnt", CondFailCount, 0);
        #1 rst = 1'b0;
        push(4'hA, 4'd6, 4'b0000, 4'hE, 1'b0);
        InValid = 1'b0;
        chk("ar_new_result", OutResult, 4'hA);
        chk("ar_new_valid", OutValid, 1);
        cycle();
        chk("ar_alone_ready", InReady, 1);
        OutReady = 1'b1;
        cycle();
        chk("ar_alone_empty", OutValid, 0);

        // saturation with NV
        any_write = 1'b0;
        for (int i = 0; i < 256; i++) begin
            push(i[3:0], 4'd0, 4'b1111, 4'hF, 1'b1);
            any_write = any_write | OutWrite;
            if (i == 0)   chk("sat_cnt1", CondFailCount, 1);
            if (i == 254) chk("sat_cnt255", CondFailCount, 255);
        end
        InValid = 1'b0;
        chk("sat_cnt_hold", CondFailCount, 255);
        chk("sat_no_write", any_write, 0);
        chk("sat_flags", FlagsOut, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
